// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the cache/backing-memory arbiter
package mem_arbiter_pkg;

    localparam int DEF_LINE_BITS = 128;
    localparam int DEF_ADDR_BITS = 16;

    typedef enum logic [2:0] {IDLE, RD_I, RD_D, WR, RESP} state_t;

    typedef enum logic [1:0] {G_NONE, G_I, G_D, G_W} grant_t;

    function automatic state_t grant_state(grant_t g);
        case (g)
            G_W:     return WR;
            G_D:     return RD_D;
            G_I:     return RD_I;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_wb_buffer.sv
// wb_buffer: one-entry write-back holding register with a full flag
module wb_buffer #(
    parameter int LINE_BITS = 128,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 drain,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [LINE_BITS-1:0] load_line,
    output logic [ADDR_BITS-1:0] addr,
    output logic [LINE_BITS-1:0] line,
    output logic                 full
);

    // a new entry always wins over a drain on the same edge so it is never lost
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            line <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= load_addr;
            line <= load_line;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I/D refills and D write-backs onto one backing line memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Ic_mem_req,
    input  logic [ADDR_BITS-1:0] Ic_mem_addr,
    output logic [LINE_BITS-1:0] F_mem_inst,
    output logic                 F_mem_valid,
    input  logic                 Dc_mem_req,
    input  logic [ADDR_BITS-1:0] Dc_mem_addr,
    output logic [LINE_BITS-1:0] MEM_data_line,
    output logic                 MEM_mem_valid,
    input  logic                 Dc_wb_we,
    input  logic [ADDR_BITS-1:0] Dc_wb_addr,
    input  logic [LINE_BITS-1:0] Dc_wb_wline,
    output logic                 Dc_wb_full,
    output logic                 Bm_req,
    output logic                 Bm_we,
    output logic [ADDR_BITS-1:0] Bm_addr,
    output logic [LINE_BITS-1:0] Bm_wline,
    input  logic [LINE_BITS-1:0] Bm_rline,
    input  logic                 Bm_valid
);

    state_t               state;
    grant_t               grant;
    logic                 last_rd;
    logic                 wb_full;
    logic                 d_req;
    logic                 drain;
    logic [ADDR_BITS-1:0] wb_addr;
    logic [LINE_BITS-1:0] wb_line;

    // a refill arriving with its own write-back pulse waits one cycle so the write goes first
    assign d_req      = Dc_mem_req && !Dc_wb_we;
    assign drain      = state == WR && Bm_valid;
    assign Dc_wb_full = wb_full;

    wb_buffer #(
        .LINE_BITS(LINE_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_wb (
        .clk      (clk),
        .rst      (rst),
        .load     (Dc_wb_we),
        .drain    (drain),
        .load_addr(Dc_wb_addr),
        .load_line(Dc_wb_wline),
        .addr     (wb_addr),
        .line     (wb_line),
        .full     (wb_full)
    );

    // next transaction source: pending write-back first, then round-robin between reads
    always_comb
        grant = wb_full ? G_W :
                (Ic_mem_req && d_req) ? (last_rd ? G_I : G_D) :
                d_req ? G_D :
                Ic_mem_req ? G_I : G_NONE;

    // arbiter FSM with registered backing-memory and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_rd       <= 1'b0;
            Bm_req        <= 1'b0;
            Bm_we         <= 1'b0;
            Bm_addr       <= '0;
            Bm_wline      <= '0;
            F_mem_inst    <= '0;
            F_mem_valid   <= 1'b0;
            MEM_data_line <= '0;
            MEM_mem_valid <= 1'b0;
        end else begin
            Bm_req        <= 1'b0;
            F_mem_valid   <= 1'b0;
            MEM_mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != G_NONE) begin
                        state    <= grant_state(grant);
                        Bm_req   <= 1'b1;
                        Bm_we    <= grant == G_W;
                        Bm_addr  <= grant == G_W ? wb_addr : grant == G_D ? Dc_mem_addr : Ic_mem_addr;
                        Bm_wline <= grant == G_W ? wb_line : '0;
                        if (grant != G_W)
                            last_rd <= grant == G_D;
                    end
                end
                RD_I: begin
                    if (Bm_valid) begin
                        F_mem_inst  <= Bm_rline;
                        F_mem_valid <= 1'b1;
                        state       <= RESP;
                    end
                end
                RD_D: begin
                    if (Bm_valid) begin
                        MEM_data_line <= Bm_rline;
                        MEM_mem_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                WR: begin
                    if (Bm_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the I-cache line-refill port, the D-cache line-refill port and the D-cache dirty-line write-back port onto one single-port backing line memory. It replaces the direct fan-in of both caches onto the unified memory and sits between the caches and the memory. Write-backs are absorbed into a one-entry buffer so the D-cache can release an evicted line before it issues the refill. Only one backing transaction is in flight at any time.

## Interface
- LINE_BITS, 128, cache line width
- ADDR_BITS, 16, line address width (PC_BITS-4)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- Ic_mem_req  in  1  I-cache refill request; level, held until F_mem_valid is seen
- Ic_mem_addr  in  ADDR_BITS  I-cache line address; stable while Ic_mem_req is high
- F_mem_inst  out  LINE_BITS  refill line to I-cache; registered, holds its last value
- F_mem_valid  out  1  one-cycle pulse; F_mem_inst is valid
- Dc_mem_req / Dc_mem_addr  in  1 / ADDR_BITS  D-cache refill; same protocol as the I-cache port
- MEM_data_line / MEM_mem_valid  out  LINE_BITS / 1  D-cache refill data and one-cycle valid pulse
- Dc_wb_we  in  1  one-cycle write-back pulse
- Dc_wb_addr / Dc_wb_wline  in  ADDR_BITS / LINE_BITS  write-back address and line
- Dc_wb_full  out  1  write buffer occupied; the D-cache must not pulse Dc_wb_we while this is high
- Bm_req  out  1  one-cycle transaction-start pulse to the backing memory
- Bm_we / Bm_addr / Bm_wline  out  1 / ADDR_BITS / LINE_BITS  transaction type, address and write data; held until Bm_valid
- Bm_rline  in  LINE_BITS  read data from the backing memory
- Bm_valid  in  1  one-cycle completion pulse for both reads and writes, LATENCY cycles after Bm_req

## Operation
- States:
  - IDLE
  - RD_I: I-cache read in flight
  - RD_D: D-cache read in flight
  - WR: write-back in flight
  - RESP: response cycle
- Grant in IDLE, evaluated every cycle with this priority:
  - The write buffer is full → WR.
  - Otherwise both read requests are high → round-robin on the last_rd bit (0 = D-cache next). A grant to D sets last_rd=1; a grant to I sets last_rd=0.
  - Otherwise the single read requester that is high is granted.
- Entering RD_x or WR: latch address, we and wline into the Bm_* outputs, and pulse Bm_req in the first cycle of the state.
- RD_x with Bm_valid: capture Bm_rline into F_mem_inst or MEM_data_line, then go to RESP. The matching valid output is high during RESP only.
- RESP: go to IDLE unconditionally. The requester drops req in the cycle after valid, so the arbiter never re-grants a stale request.
- WR with Bm_valid: clear the buffer and go to IDLE. No response is sent to the D-cache.
- Write buffer:
  - A Dc_wb_we pulse loads the buffer and sets full.
  - If the pulse arrives on the same edge the buffer is granted to WR, the new entry is loaded and full stays 1.
- A D-cache refill whose address matches a pending write-back is always ordered after it, because WR has priority.
- Bm_valid in IDLE or RESP is ignored.
- Reset values:
  - state=IDLE, last_rd=0, buffer empty.
  - All outputs are 0: Bm_req, Bm_we, Bm_addr, Bm_wline, F_mem_inst, F_mem_valid, MEM_data_line, MEM_mem_valid, Dc_wb_full.
- Reset mid-transaction: abandon the transaction and drop the buffered write-back. A late Bm_valid is ignored.

## Timing
- Read: request first high in IDLE at cycle 0 → Bm_req in cycle 1 → Bm_valid in cycle 1+LATENCY → valid pulse in cycle 2+LATENCY.
- With LATENCY=3, the valid pulse is in cycle 5. The next grant is possible no earlier than cycle 3+LATENCY.
- Write-back: Dc_wb_we in cycle 0 → Dc_wb_full high from cycle 1. If the arbiter is IDLE, Bm_req (we=1) is in cycle 2.
- Dc_wb_full falls in the cycle after Bm_valid.
- No combinational path from any input to any output.

## Structure
- Package mem_arbiter_pkg holds:
  - the state enum (IDLE, RD_I, RD_D, WR, RESP)
  - a default LINE_BITS/ADDR_BITS localparam
  - the grant-source encoding
- Sub-module wb_buffer: one-entry register of addr and line with a full flag, a load pulse and a drain pulse.
- The arbiter FSM and output registers stay in mem_arbiter.

## Test plan
1. Backing memory model with LATENCY=3. Ic_mem_req=1 with addr 0x0012 from cycle 0 → Bm_req with addr 0x0012 and we=0 in cycle 1. F_mem_valid pulses for 1 cycle in cycle 5 with F_mem_inst = model line. MEM_mem_valid stays 0.
2. Ic_mem_req and Dc_mem_req both high from reset → D-cache granted first. After the D response and RESP, the I-cache is granted with Bm_req in cycle 7 and F_mem_valid in cycle 11.
3. Dc_wb_we with addr 0x0040 in the same cycle as Dc_mem_req with addr 0x0040 → write transaction (we=1) first, then the read. The read returns the written line.
4. Dc_wb_we while a read is in flight → Dc_wb_full=1 until the write completes. The write is issued immediately after the read's RESP cycle, ahead of a pending I-cache request.
5. rst asserted for 1 cycle while in RD_D, with Bm_valid arriving 2 cycles later → all outputs 0 and state IDLE. No MEM_mem_valid pulse.
6. Continuous alternating I and D requests for 20 transactions → grants strictly alternate. No requester waits more than one transaction.
